fetch_unit: RTL
===============

# fetch_unit

Instruction fetch unit: the register and handshake end of the PC incrementer. It holds the architectural program counter and issues one instruction-memory read at a time. It presents each returned instruction with its PC to decode over a valid/ready handshake, and advances the PC by a constant step or redirects it to a branch/jump target. It sits between instruction memory and the decode stage. It is the only owner of the PC register in the CPU.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 32'd4, sequential increment added to PC per consumed instruction
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request pending
- imem_req_addr  output  32  fetch address (current PC)
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  read data valid (one pulse per accepted request)
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  branch/jump taken; load redirect_pc
- redirect_pc  input  32  target address; bits [1:0] ignored (forced 2'b00)
- inst_valid  output  1  instruction held for decode
- inst_data  output  32  held instruction word
- inst_pc  output  32  address the held instruction was fetched from
- inst_ready  input  1  decode accepts held instruction

## Operation
- States: IDLE, REQ, WAIT, HOLD. Internal: pc[31:0], drop flag.
- IDLE: entered only from reset. Goes to REQ unconditionally next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On valid&&ready: go to WAIT.
  - On redirect_valid: pc<=redirect_pc and stay in REQ, even if ready is also high. The request is not counted; the memory must drop it. Address changes while valid are legal only on redirect.
- WAIT: imem_req_valid=0.
  - On rsp_valid with drop=0: capture inst_data<=rsp_data, inst_pc<=pc, go to HOLD.
  - On redirect_valid with no response yet: pc<=redirect_pc, drop<=1, stay in WAIT.
  - On rsp_valid with drop=1, or rsp_valid together with redirect_valid: discard the data, drop<=0, go to REQ. If redirect_valid is set in the same cycle, pc<=redirect_pc.
- HOLD:
  - inst_valid=1. inst_data and inst_pc are stable until handshake or redirect.
  - On inst_valid&&inst_ready: pc<=pc+PC_STEP, go to REQ.
  - On redirect_valid: pc<=redirect_pc, inst_valid drops, go to REQ. Redirect overrides a simultaneous inst_ready for next-PC selection; the held instruction still counts as consumed.
- Arithmetic: pc+PC_STEP is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000; no flag is raised.
- imem_rsp_valid in IDLE, REQ or HOLD is ignored.
- rst asserted mid-operation: all state clears immediately. Any in-flight response after release is ignored, because the state is not WAIT.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
- imem_req_valid and inst_valid are decoded from registered state only. No combinational path from any input to any output.
- First request: imem_req_valid rises in the second rising edge's cycle after rst deasserts.
- Request accepted at edge N: memory may return imem_rsp_valid at cycle N+1 or later. inst_valid rises the cycle after imem_rsp_valid is sampled.
- Zero-wait memory with decode always ready: one instruction per 3 cycles (REQ, WAIT, HOLD).
- At most one outstanding request at any time.

## Test plan
- Reset: rst=1 async mid-cycle -> all outputs at reset values immediately. After release, imem_req_addr=0 with valid=1 on the second cycle.
- Sequential fetch, zero-wait memory, inst_ready=1: inst_pc sequence 0x0, 0x4, 0x8, 0xC, with inst_data matching the memory model, one every 3 cycles.
- Decode stall: inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_data, inst_pc unchanged and no new request. Release -> next request at addr+4.
- Redirect in WAIT (memory latency 3 cycles), redirect_pc=0x100 -> the stale response is dropped, inst_valid never asserts for it, the next request is addr 0x100, and inst_pc=0x100 follows.
- Redirect with inst_ready in the same HOLD cycle, redirect_pc=0x203 -> next request addr 0x200, not pc+4.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address is 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, redirect and decode handshake bundle for
//               the fetch unit. "master" is the fetch unit side, "slave" is
//               the memory/decode/branch side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Owns the architectural PC, issues one instruction fetch at a
//               time and hands each returned word plus its PC to decode.
//               Redirects replace the PC; a redirect while a read is in
//               flight marks the response to be dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;
    logic        r_drop;
    logic [31:0] w_redir_pc;

    // Redirect targets are always word aligned.
    assign w_redir_pc = bus.redirect_pc & ~32'h0000_0003;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a redirect in REQ cancels the handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (!bus.redirect_valid && bus.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = (r_drop || bus.redirect_valid) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid || bus.inst_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // PC, drop flag and held instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_data <= 32'h0000_0000;
            r_inst_pc   <= RESET_PC;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (r_drop || bus.redirect_valid) begin
                            // Stale or superseded response: discard it.
                            r_drop <= 1'b0;
                            if (bus.redirect_valid) begin
                                r_pc <= w_redir_pc;
                            end
                        end else begin
                            r_inst_data <= bus.imem_rsp_data;
                            r_inst_pc   <= r_pc;
                        end
                    end else if (bus.redirect_valid) begin
                        // Read still in flight; remember to throw it away.
                        r_pc   <= w_redir_pc;
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end else if (bus.inst_ready) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_valid = (r_state == S_REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == S_HOLD);
    assign bus.inst_data      = r_inst_data;
    assign bus.inst_pc        = r_inst_pc;

endmodule
`default_nettype wire
